seg7_scan_rx: RTL
=================

SEG7_SCAN_RX -- requirements
Module: seg7_scan_rx

Interface
REQ-001 Parameter STABLE_CYC, default 4, number of consecutive identical sample cycles required before a digit is captured (legal range 1..255).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 an  input  8  active-low digit anodes; an[i]==0 selects digit i.
REQ-005 seg_n  input  8  active-low segments; bit0..6 = a..g, bit7 = decimal point.
REQ-006 value  output  32  captured hex frame; digit i in value[4i+3:4i].
REQ-007 point  output  8  captured decimal points, active-high (point[i] = ~seg_n[7] of digit i).
REQ-008 blank  output  8  blank[i]=1 when digit i showed all seven segments off (seg_n[6:0]==7'h7F).
REQ-009 err  output  8  err[i]=1 when digit i showed a pattern that is neither a hex glyph nor blank.
REQ-010 frame_valid  output  1  level, high once at least one complete frame has been published.
REQ-011 frame_pulse  output  1  one-cycle strobe on each frame publication.

Function
REQ-012 Decoder SHALL map seg_n[6:0] (g..a) to nibbles: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F (hex).
REQ-013 Blank pattern SHALL store nibble 0, blank=1, err=0; unmatched pattern SHALL store nibble 0, err=1, blank=0.
REQ-014 Anode input SHALL be valid only when exactly one bit of an is 0; any other value is "no digit".
REQ-015 FSM states: HUNT, SETTLE, HOLD.
REQ-016 HUNT: on valid anode, latch digit index and {an,seg_n} sample, counter=1, go SETTLE (if STABLE_CYC==1, capture immediately and go HOLD).
REQ-017 SETTLE: sample equal to latched -> counter+1; counter reaching STABLE_CYC -> capture, go HOLD.
REQ-018 SETTLE: sample differs but anode still valid -> relatch new sample, counter=1, stay SETTLE; no-digit -> HUNT, counter=0.
REQ-019 HOLD: unchanged sample -> stay, no further capture; changed valid sample -> relatch, SETTLE; no-digit -> HUNT.
REQ-020 Capture SHALL write nibble, point, blank, err of digit i into shadow registers and set seen[i]; recapture of a digit already seen SHALL overwrite its shadow entry.
REQ-021 When a capture makes seen==8'hFF, in that same cycle shadow (including the current digit) SHALL be copied to value/point/blank/err on the next edge, frame_pulse=1 for one cycle, frame_valid=1, seen cleared.
REQ-022 Outputs SHALL change only on frame publication; latency from final capture cycle to outputs/pulse = 1 clk.
REQ-023 Counter SHALL saturate and never wrap; shadow and outputs SHALL never contain partial frames.

Reset
REQ-024 rst SHALL force value=0, point=0, blank=0, err=0, frame_valid=0, frame_pulse=0, seen=0, shadow=0, counter=0, state HUNT.
REQ-025 rst asserted mid-frame or mid-settle SHALL discard all partial data; rst has priority over every other event.

Verification
REQ-026 Scan digits 0..7 showing 0,1,...,7 (patterns 40,79,24,30,19,12,02,78), each 6 cycles, p off -> value=32'h76543210, point=0, blank=0, err=0, one frame_pulse, frame_valid=1.
REQ-027 Digit 3 held only 3 cycles (STABLE_CYC=4) then scan continues -> no publication until digit 3 later held >=4 cycles.
REQ-028 Digit 5 blank (7F), digit 2 pattern 7'h55, digit 0 p on, others show 8 -> blank=8'h20, err=8'h04, point=8'h01, value nibbles 2 and 5 = 0, others 8.
REQ-029 an=8'hFC (two digits low) for 20 cycles -> no capture, state stays HUNT, seen unchanged.
REQ-030 rst pulsed after 5 digits captured, then full scan of all F -> single frame_pulse, value=32'hFFFFFFFF, no data from pre-reset digits.
REQ-031 Digit 4 changes 9->A while anode held after capture -> recapture, published nibble 4 = A.

Source files
------------

// File: rtl/seg7_scan_rx.sv
// seg7_scan_rx: recovers the hex frame shown on a multiplexed 8-digit
// active-low seven-segment display by watching its anode and segment lines.
module seg7_scan_rx #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [7:0]  seg_n,
  output logic [31:0] value,
  output logic [7:0]  point,
  output logic [7:0]  blank,
  output logic [7:0]  err,
  output logic        frame_valid,
  output logic        frame_pulse
);

  localparam int unsigned NDIG  = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned SMP_W = 16;

  typedef enum logic [1:0] {HUNT, SETTLE, HOLD} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SMP_W-1:0]   samp_q, samp_d;
  logic [NDIG-1:0]    seen_q, seen_d;
  logic [4*NDIG-1:0]  sh_val_q, sh_val_d;
  logic [NDIG-1:0]    sh_pt_q, sh_pt_d;
  logic [NDIG-1:0]    sh_bl_q, sh_bl_d;
  logic [NDIG-1:0]    sh_er_q, sh_er_d;
  logic [4*NDIG-1:0]  value_q, value_d;
  logic [NDIG-1:0]    point_q, point_d;
  logic [NDIG-1:0]    blank_q, blank_d;
  logic [NDIG-1:0]    err_q, err_d;
  logic               valid_q, valid_d;
  logic               pulse_q, pulse_d;

  logic [NDIG-1:0]    an_low_c;
  logic               an_valid_c;
  logic [IDX_W-1:0]   idx_c;
  logic [SMP_W-1:0]   sample_c;
  logic [3:0]         nib_c;
  logic               is_blank_c;
  logic               is_err_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               capture_c;

  // Anode qualification (exactly one digit low) and digit index encode
  always_comb begin
    an_low_c   = ~an;
    an_valid_c = (an_low_c != '0) && ((an_low_c & (an_low_c - 8'd1)) == '0);
    idx_c      = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (an_low_c[i]) idx_c = IDX_W'(i);
    end
    sample_c   = {an, seg_n};
  end

  // Segment pattern (g..a, active low) to hex nibble, blank or error
  always_comb begin
    nib_c      = 4'h0;
    is_blank_c = 1'b0;
    is_err_c   = 1'b0;
    case (seg_n[6:0])
      7'h40: nib_c = 4'h0;
      7'h79: nib_c = 4'h1;
      7'h24: nib_c = 4'h2;
      7'h30: nib_c = 4'h3;
      7'h19: nib_c = 4'h4;
      7'h12: nib_c = 4'h5;
      7'h02: nib_c = 4'h6;
      7'h78: nib_c = 4'h7;
      7'h00: nib_c = 4'h8;
      7'h10: nib_c = 4'h9;
      7'h08: nib_c = 4'hA;
      7'h03: nib_c = 4'hB;
      7'h46: nib_c = 4'hC;
      7'h21: nib_c = 4'hD;
      7'h06: nib_c = 4'hE;
      7'h0E: nib_c = 4'hF;
      7'h7F: is_blank_c = 1'b1;
      default: is_err_c = 1'b1;
    endcase
  end

  // Digit acquisition FSM: wait for a digit, require a stable sample, then hold
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    samp_d    = samp_q;
    capture_c = 1'b0;
    cnt_inc_c = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      HUNT: begin
        if (an_valid_c) begin
          samp_d = sample_c;
          cnt_d  = CNT_W'(1);
          if (STABLE_CYC <= 1) begin
            capture_c = 1'b1;
            state_d   = HOLD;
          end else begin
            state_d   = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (!an_valid_c) begin
          state_d = HUNT;
          cnt_d   = '0;
        end else if (sample_c == samp_q) begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c >= CNT_W'(STABLE_CYC)) begin
            capture_c = 1'b1;
            state_d   = HOLD;
          end
        end else begin
          samp_d = sample_c;
          cnt_d  = CNT_W'(1);
        end
      end
      HOLD: begin
        if (!an_valid_c) begin
          state_d = HUNT;
          cnt_d   = '0;
        end else if (sample_c != samp_q) begin
          samp_d = sample_c;
          cnt_d  = CNT_W'(1);
          if (STABLE_CYC <= 1) begin
            capture_c = 1'b1;
          end else begin
            state_d = SETTLE;
          end
        end
      end
      default: begin
        state_d = HUNT;
        cnt_d   = '0;
      end
    endcase
  end

  // Shadow capture and whole-frame publication once every digit has been seen
  always_comb begin
    seen_d   = seen_q;
    sh_val_d = sh_val_q;
    sh_pt_d  = sh_pt_q;
    sh_bl_d  = sh_bl_q;
    sh_er_d  = sh_er_q;
    value_d  = value_q;
    point_d  = point_q;
    blank_d  = blank_q;
    err_d    = err_q;
    valid_d  = valid_q;
    pulse_d  = 1'b0;
    if (capture_c) begin
      sh_val_d[{idx_c, 2'b00} +: 4] = nib_c;
      sh_pt_d[idx_c]                = ~seg_n[7];
      sh_bl_d[idx_c]                = is_blank_c;
      sh_er_d[idx_c]                = is_err_c;
      seen_d[idx_c]                 = 1'b1;
      if (seen_d == {NDIG{1'b1}}) begin
        value_d = sh_val_d;
        point_d = sh_pt_d;
        blank_d = sh_bl_d;
        err_d   = sh_er_d;
        valid_d = 1'b1;
        pulse_d = 1'b1;
        seen_d  = '0;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      samp_q   <= '0;
      seen_q   <= '0;
      sh_val_q <= '0;
      sh_pt_q  <= '0;
      sh_bl_q  <= '0;
      sh_er_q  <= '0;
      value_q  <= '0;
      point_q  <= '0;
      blank_q  <= '0;
      err_q    <= '0;
      valid_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      samp_q   <= samp_d;
      seen_q   <= seen_d;
      sh_val_q <= sh_val_d;
      sh_pt_q  <= sh_pt_d;
      sh_bl_q  <= sh_bl_d;
      sh_er_q  <= sh_er_d;
      value_q  <= value_d;
      point_q  <= point_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      pulse_q  <= pulse_d;
    end
  end

  assign value       = value_q;
  assign point       = point_q;
  assign blank       = blank_q;
  assign err         = err_q;
  assign frame_valid = valid_q;
  assign frame_pulse = pulse_q;

endmodule
